// File: rtl/node_msg_port.sv
// Self-port endpoint: packs PU requests into mesh messages toward the router
// mailbox, and filters/buffers router outqueue traffic for delivery to the PU.
module node_msg_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] wdata_i,
    output logic [W-1:0] rdata_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage is deliberately left unreset; the pointers define validity.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end
endmodule

module node_msg_port #(
    parameter int CORDINATE_WIDTH = 4,
    parameter int COST_WIDTH      = 2,
    parameter int MAX_HOP_WIDTH   = 3,
    parameter int TIMESTAMP_WIDTH = 8,
    parameter int MSG_TYPE_WIDTH  = 2,
    parameter int MSG_WIDTH       = 6*CORDINATE_WIDTH + COST_WIDTH +
                                    MAX_HOP_WIDTH + TIMESTAMP_WIDTH +
                                    MSG_TYPE_WIDTH,
    parameter int BODY_WIDTH      = MSG_WIDTH - 4*CORDINATE_WIDTH,
    parameter int TX_DEPTH        = 4,
    parameter int RX_DEPTH        = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [CORDINATE_WIDTH-1:0] ROW_ID,
    input  logic [CORDINATE_WIDTH-1:0] COL_ID,
    input  logic                       tx_valid_in,
    output logic                       tx_ready_out,
    input  logic [CORDINATE_WIDTH-1:0] tx_dest_row,
    input  logic [CORDINATE_WIDTH-1:0] tx_dest_col,
    input  logic [BODY_WIDTH-1:0]      tx_body,
    output logic [MSG_WIDTH-1:0]       mailbox_value_out,
    output logic                       mailbox_valid_out,
    input  logic                       mailbox_ready_in,
    input  logic [MSG_WIDTH-1:0]       outqueue_value_in,
    input  logic                       outqueue_valid_in,
    output logic                       outqueue_ready_out,
    output logic                       rx_valid_out,
    input  logic                       rx_ready_in,
    output logic [CORDINATE_WIDTH-1:0] rx_src_row,
    output logic [CORDINATE_WIDTH-1:0] rx_src_col,
    output logic [BODY_WIDTH-1:0]      rx_body,
    output logic                       idle,
    output logic                       err_misroute,
    output logic [15:0]                tx_count,
    output logic [15:0]                rx_count,
    output logic [15:0]                drop_count
);
    localparam int CW  = CORDINATE_WIDTH;
    localparam int RXW = MSG_WIDTH - 2*CW;

    logic                 tx_full, tx_empty, tx_push, tx_pop;
    logic [MSG_WIDTH-1:0] tx_head, tx_msg;
    logic                 rx_full, rx_empty, rx_push, rx_pop;
    logic                 rx_hs, rx_match, rx_drop;
    logic [RXW-1:0]       rx_head;
    logic [2*CW-1:0]      rx_dest;

    logic [15:0] tx_count_q, tx_count_d;
    logic [15:0] rx_count_q, rx_count_d;
    logic [15:0] drop_count_q, drop_count_d;
    logic        err_q, err_d;

    assign tx_ready_out = ~tx_full;
    assign tx_push      = tx_valid_in & ~tx_full;
    assign tx_msg       = {tx_dest_row, tx_dest_col, ROW_ID, COL_ID, tx_body};

    // The router writes on valid alone, so valid must be gated by ready.
    assign mailbox_valid_out = ~tx_empty & mailbox_ready_in;
    assign tx_pop            = mailbox_valid_out;
    assign mailbox_value_out = tx_empty ? '0 : tx_head;

    node_msg_fifo #(.W(MSG_WIDTH), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (tx_push),
        .pop_i   (tx_pop),
        .wdata_i (tx_msg),
        .rdata_o (tx_head),
        .full_o  (tx_full),
        .empty_o (tx_empty)
    );

    assign outqueue_ready_out = ~rx_full;
    assign rx_hs    = outqueue_valid_in & ~rx_full;
    assign rx_dest  = outqueue_value_in[MSG_WIDTH-1 -: 2*CW];
    assign rx_match = (rx_dest == {ROW_ID, COL_ID}) && (rx_dest != '1);
    assign rx_push  = rx_hs & rx_match;
    assign rx_drop  = rx_hs & ~rx_match;

    assign rx_valid_out = ~rx_empty;
    assign rx_pop       = rx_valid_out & rx_ready_in;
    assign rx_src_row   = rx_empty ? '0 : rx_head[RXW-1 -: CW];
    assign rx_src_col   = rx_empty ? '0 : rx_head[RXW-CW-1 -: CW];
    assign rx_body      = rx_empty ? '0 : rx_head[BODY_WIDTH-1:0];

    node_msg_fifo #(.W(RXW), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (rx_push),
        .pop_i   (rx_pop),
        .wdata_i (outqueue_value_in[RXW-1:0]),
        .rdata_o (rx_head),
        .full_o  (rx_full),
        .empty_o (rx_empty)
    );

    // Any handshake in flight this cycle also counts as activity.
    assign idle = tx_empty & rx_empty & ~tx_push & ~rx_hs &
                  ~mailbox_valid_out & ~rx_valid_out;

    always_comb begin
        tx_count_d   = tx_count_q;
        rx_count_d   = rx_count_q;
        drop_count_d = drop_count_q;
        err_d        = err_q;
        if (tx_pop && tx_count_q != 16'hFFFF)
            tx_count_d = tx_count_q + 16'd1;
        if (rx_push && rx_count_q != 16'hFFFF)
            rx_count_d = rx_count_q + 16'd1;
        if (rx_drop) begin
            err_d = 1'b1;
            if (drop_count_q != 16'hFFFF)
                drop_count_d = drop_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_count_q   <= '0;
            rx_count_q   <= '0;
            drop_count_q <= '0;
            err_q        <= 1'b0;
        end else begin
            tx_count_q   <= tx_count_d;
            rx_count_q   <= rx_count_d;
            drop_count_q <= drop_count_d;
            err_q        <= err_d;
        end
    end

    assign tx_count     = tx_count_q;
    assign rx_count     = rx_count_q;
    assign drop_count   = drop_count_q;
    assign err_misroute = err_q;
endmodule

// File: tb/tb_node_msg_port.sv
// Bench for node_msg_port: directed table, corner sequences and random
// traffic checked against a queue-based reference model.
module tb_node_msg_port;
    localparam int CW = 4;
    localparam int MW = 39;
    localparam int BW = 23;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [CW-1:0] row_id = 4'd2;
    logic [CW-1:0] col_id = 4'd3;
    logic          tx_v = 1'b0, mb_rdy = 1'b0, oq_v = 1'b0, rx_rdy = 1'b0;
    logic [CW-1:0] dr = '0, dc = '0;
    logic [BW-1:0] body = '0;
    logic [MW-1:0] oq_msg = '0;

    logic          tx_ready_out, mb_valid, oq_ready, rx_valid;
    logic [MW-1:0] mb_value;
    logic [CW-1:0] rx_src_row, rx_src_col;
    logic [BW-1:0] rx_body;
    logic          idle, err_misroute;
    logic [15:0]   tx_count, rx_count, drop_count;

    always #5 clk = ~clk;

    node_msg_port dut (
        .clk                (clk),
        .reset              (reset),
        .ROW_ID             (row_id),
        .COL_ID             (col_id),
        .tx_valid_in        (tx_v),
        .tx_ready_out       (tx_ready_out),
        .tx_dest_row        (dr),
        .tx_dest_col        (dc),
        .tx_body            (body),
        .mailbox_value_out  (mb_value),
        .mailbox_valid_out  (mb_valid),
        .mailbox_ready_in   (mb_rdy),
        .outqueue_value_in  (oq_msg),
        .outqueue_valid_in  (oq_v),
        .outqueue_ready_out (oq_ready),
        .rx_valid_out       (rx_valid),
        .rx_ready_in        (rx_rdy),
        .rx_src_row         (rx_src_row),
        .rx_src_col         (rx_src_col),
        .rx_body            (rx_body),
        .idle               (idle),
        .err_misroute       (err_misroute),
        .tx_count           (tx_count),
        .rx_count           (rx_count),
        .drop_count         (drop_count)
    );

    int errors = 0;
    int checks = 0;

    logic [MW-1:0] txq[$];
    logic [MW-1:0] rxq[$];
    int  m_tc, m_rc, m_dc;
    bit  m_err;

    function automatic logic [MW-1:0] mk(input logic [CW-1:0] a,
            input logic [CW-1:0] b, input logic [CW-1:0] c,
            input logic [CW-1:0] d, input logic [BW-1:0] bd);
        return {a, b, c, d, bd};
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        txq.delete();
        rxq.delete();
        m_tc = 0;
        m_rc = 0;
        m_dc = 0;
        m_err = 0;
    endtask

    task automatic model_check();
        logic [MW-1:0] h;
        bit e_txr, e_oqr, e_mbv, e_rxv, e_idle;
        e_txr = txq.size() < DEPTH;
        e_oqr = rxq.size() < DEPTH;
        e_mbv = (txq.size() != 0) && mb_rdy;
        e_rxv = rxq.size() != 0;
        e_idle = (txq.size() == 0) && (rxq.size() == 0) &&
                 !(tx_v && e_txr) && !(oq_v && e_oqr);
        h = e_rxv ? rxq[0] : '0;
        chk("tx_ready", tx_ready_out, e_txr);
        chk("oq_ready", oq_ready, e_oqr);
        chk("mb_valid", mb_valid, e_mbv);
        chk("mb_value", mb_value, txq.size() != 0 ? txq[0] : '0);
        chk("rx_valid", rx_valid, e_rxv);
        chk("rx_src_row", rx_src_row, h[MW-2*CW-1 -: CW]);
        chk("rx_src_col", rx_src_col, h[MW-3*CW-1 -: CW]);
        chk("rx_body", rx_body, h[BW-1:0]);
        chk("idle", idle, e_idle);
        chk("tx_count", tx_count, m_tc);
        chk("rx_count", rx_count, m_rc);
        chk("drop_count", drop_count, m_dc);
        chk("err_misroute", err_misroute, m_err);
    endtask

    task automatic model_update();
        bit txr, oqr, mbv, rxv;
        if (reset) begin
            model_clear();
            return;
        end
        txr = txq.size() < DEPTH;
        oqr = rxq.size() < DEPTH;
        mbv = (txq.size() != 0) && mb_rdy;
        rxv = rxq.size() != 0;
        if (mbv) begin
            void'(txq.pop_front());
            if (m_tc < 65535) m_tc++;
        end
        if (rxv && rx_rdy) void'(rxq.pop_front());
        if (tx_v && txr) txq.push_back(mk(dr, dc, row_id, col_id, body));
        if (oq_v && oqr) begin
            if (oq_msg[MW-1 -: 2*CW] == {row_id, col_id} &&
                oq_msg[MW-1 -: 2*CW] != 8'hFF) begin
                rxq.push_back(oq_msg);
                if (m_rc < 65535) m_rc++;
            end else begin
                if (m_dc < 65535) m_dc++;
                m_err = 1;
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        model_check();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle_inputs();
        tx_v = 0;
        oq_v = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1;
        step();
        reset = 0;
    endtask

    typedef struct {
        logic          tx_v;
        logic [CW-1:0] dr, dc;
        logic [BW-1:0] body;
        logic          mb_rdy;
        logic          oq_v;
        logic [MW-1:0] oq_msg;
        logic          rx_rdy;
        logic          e_mbv;
        logic [MW-1:0] e_mbval;
        logic          e_rxv;
        logic [BW-1:0] e_rxbody;
        logic          e_idle;
    } vec_t;

    vec_t vt[9];

    initial begin
        vt[0] = '{1, 1, 3, 23'h1A5, 1, 0, '0, 1, 0, '0, 0, '0, 0};
        vt[1] = '{0, 0, 0, '0, 1, 0, '0, 1, 1, mk(1, 3, 2, 3, 23'h1A5),
                  0, '0, 0};
        vt[2] = '{0, 0, 0, '0, 1, 0, '0, 1, 0, '0, 0, '0, 1};
        vt[3] = '{0, 0, 0, '0, 1, 1, mk(2, 4, 0, 0, 23'h7), 1,
                  0, '0, 0, '0, 0};
        vt[4] = '{0, 0, 0, '0, 1, 1, mk(15, 15, 0, 0, 23'h8), 1,
                  0, '0, 0, '0, 0};
        vt[5] = '{0, 0, 0, '0, 1, 0, '0, 1, 0, '0, 0, '0, 1};
        vt[6] = '{0, 0, 0, '0, 1, 1, mk(2, 3, 0, 0, 23'h55), 0,
                  0, '0, 0, '0, 0};
        vt[7] = '{0, 0, 0, '0, 1, 0, '0, 1, 0, '0, 1, 23'h55, 0};
        vt[8] = '{0, 0, 0, '0, 1, 0, '0, 1, 0, '0, 0, '0, 1};

        model_clear();
        repeat (2) @(posedge clk);
        #1;
        reset = 0;
        chk("rst_idle", idle, 1);
        chk("rst_tx_ready", tx_ready_out, 1);
        chk("rst_oq_ready", oq_ready, 1);
        chk("rst_mb_valid", mb_valid, 0);
        chk("rst_rx_valid", rx_valid, 0);

        for (int i = 0; i < 9; i++) begin
            tx_v = vt[i].tx_v;
            dr = vt[i].dr;
            dc = vt[i].dc;
            body = vt[i].body;
            mb_rdy = vt[i].mb_rdy;
            oq_v = vt[i].oq_v;
            oq_msg = vt[i].oq_msg;
            rx_rdy = vt[i].rx_rdy;
            @(negedge clk);
            chk($sformatf("vec%0d_mb_valid", i), mb_valid, vt[i].e_mbv);
            chk($sformatf("vec%0d_mb_value", i), mb_value, vt[i].e_mbval);
            chk($sformatf("vec%0d_rx_valid", i), rx_valid, vt[i].e_rxv);
            chk($sformatf("vec%0d_rx_body", i), rx_body, vt[i].e_rxbody);
            chk($sformatf("vec%0d_idle", i), idle, vt[i].e_idle);
            model_check();
            @(posedge clk);
            model_update();
            #1;
        end
        chk("vec_tx_count", tx_count, 1);
        chk("vec_rx_count", rx_count, 1);
        chk("vec_drop_count", drop_count, 2);
        chk("vec_err", err_misroute, 1);

        // TX backpressure: mailbox blocked, five requests offered.
        do_reset();
        mb_rdy = 0;
        for (int i = 0; i < 5; i++) begin
            tx_v = 1;
            dr = 4'(i);
            dc = 4'd1;
            body = 23'(i + 16);
            step();
        end
        tx_v = 0;
        chk("txbp_ready_low", tx_ready_out, 0);
        chk("txbp_no_valid", mb_valid, 0);
        mb_rdy = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("txbp_order", mb_value, mk(4'(i), 1, 2, 3, 23'(i + 16)));
            chk("txbp_valid", mb_valid, 1);
            step();
        end
        chk("txbp_count", tx_count, 4);
        chk("txbp_empty", mb_valid, 0);

        // RX backpressure: PU stalled, five own-addressed messages offered.
        do_reset();
        rx_rdy = 0;
        for (int i = 0; i < 5; i++) begin
            oq_v = 1;
            oq_msg = mk(2, 3, 0, 0, 23'(i + 32));
            step();
        end
        oq_v = 0;
        chk("rxbp_ready_low", oq_ready, 0);
        rx_rdy = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("rxbp_body", rx_body, 23'(i + 32));
            chk("rxbp_src", {rx_src_row, rx_src_col}, 8'h00);
            step();
        end
        chk("rxbp_count", rx_count, 4);
        chk("rxbp_empty", rx_valid, 0);

        // Concurrent streaming on both sides.
        do_reset();
        mb_rdy = 1;
        rx_rdy = 1;
        for (int i = 0; i < 20; i++) begin
            tx_v = 1;
            dr = 4'd5;
            dc = 4'd6;
            body = 23'(i);
            oq_v = 1;
            oq_msg = mk(2, 3, 1, 1, 23'(i + 100));
            #1;
            chk("conc_idle", idle, 0);
            chk("conc_tx_ready", tx_ready_out, 1);
            chk("conc_oq_ready", oq_ready, 1);
            step();
        end
        idle_inputs();
        step();
        step();
        chk("conc_drained_idle", idle, 1);
        chk("conc_tx_count", tx_count, 20);
        chk("conc_rx_count", rx_count, 20);

        // Reset with three entries held in each FIFO.
        do_reset();
        mb_rdy = 0;
        rx_rdy = 0;
        for (int i = 0; i < 3; i++) begin
            tx_v = 1;
            dr = 4'd7;
            dc = 4'd7;
            body = 23'(i);
            oq_v = 1;
            oq_msg = mk(2, 3, 4, 4, 23'(i));
            step();
        end
        do_reset();
        #1;
        chk("rstt_mb_valid", mb_valid, 0);
        chk("rstt_rx_valid", rx_valid, 0);
        chk("rstt_rx_count", rx_count, 0);
        chk("rstt_idle", idle, 1);
        mb_rdy = 1;
        tx_v = 1;
        dr = 4'd1;
        dc = 4'd3;
        body = 23'h0AB;
        step();
        tx_v = 0;
        #1;
        chk("rstt_new_valid", mb_valid, 1);
        chk("rstt_new_value", mb_value, mk(1, 3, 2, 3, 23'h0AB));
        step();
        step();

        // Random traffic against the reference model.
        for (int i = 0; i < 3000; i++) begin
            int sel;
            tx_v = $urandom_range(0, 1);
            dr = 4'($urandom);
            dc = 4'($urandom);
            body = 23'($urandom);
            mb_rdy = $urandom_range(0, 3) != 0;
            rx_rdy = $urandom_range(0, 2) != 0;
            oq_v = $urandom_range(0, 1);
            sel = $urandom_range(0, 3);
            case (sel)
                1: oq_msg = mk(4'hF, 4'hF, 4'($urandom), 4'($urandom),
                               23'($urandom));
                2: oq_msg = mk(4'($urandom), 4'($urandom), 4'($urandom),
                               4'($urandom), 23'($urandom));
                default: oq_msg = mk(2, 3, 4'($urandom), 4'($urandom),
                                     23'($urandom));
            endcase
            reset = ($urandom_range(0, 299) == 0);
            step();
        end
        reset = 0;
        idle_inputs();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
